// File: rtl/fft8_seq_ctrl_if.sv
// Keypad/FFT-core handshake bundle for the FFT calculator sequencer.
// The master side drives the keypad pulses and i_fft_done. The slave side is the sequencer.
interface fft8_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int N      = 8,
  parameter int IDX_W  = 3
);
  logic                  i_digit_vld;
  logic [3:0]            i_digit;
  logic                  i_next;
  logic                  i_enter;
  logic                  i_reim;
  logic                  i_clear;
  logic                  i_fft_done;
  logic                  o_fft_start;
  logic [N*DATA_W-1:0]   o_fft_x;
  logic [DATA_W-1:0]     o_entry_val;
  logic [IDX_W-1:0]      o_index;
  logic                  o_show_fft;
  logic                  o_re_im;
  logic                  o_err;

  modport master (
    output i_digit_vld, i_digit, i_next, i_enter, i_reim, i_clear, i_fft_done,
    input  o_fft_start, o_fft_x, o_entry_val, o_index, o_show_fft, o_re_im, o_err
  );

  modport slave (
    input  i_digit_vld, i_digit, i_next, i_enter, i_reim, i_clear, i_fft_done,
    output o_fft_start, o_fft_x, o_entry_val, o_index, o_show_fft, o_re_im, o_err
  );
endinterface

// File: rtl/fft8_seq_ctrl.sv
// Mode sequencer for the keypad FFT calculator: decimal sample entry into an
// N-deep buffer, FFT launch with done timeout, and bin/Re-Im stepping for display.
module fft8_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int N       = 8,
  parameter int IDX_W   = 3,
  parameter int DONE_TO = 64
) (
  input  logic i_clk,
  input  logic i_rstn,
  fft8_seq_ctrl_if.slave bus
);

  localparam int CNT_W = IDX_W + 1;
  localparam int TMR_W = $clog2(DONE_TO + 1);
  localparam int MAC_W = DATA_W + 5;

  typedef enum logic [2:0] {ST_ENTRY, ST_START, ST_WAIT, ST_SHOW, ST_ERR} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   smp_q [N];
  logic [DATA_W-1:0]   smp_d [N];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   entry_q, entry_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic                reim_q, reim_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;
  logic                digit_ok;

  // entry*10 + digit, clamped to the largest unsigned sample value
  function automatic logic [DATA_W-1:0] sat_mac(input logic [DATA_W-1:0] v, input logic [3:0] d);
    logic [MAC_W-1:0] t;
    t = (MAC_W'(v) * MAC_W'(10)) + MAC_W'(d);
    if (t > MAC_W'({DATA_W{1'b1}})) sat_mac = {DATA_W{1'b1}};
    else                            sat_mac = t[DATA_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N-1)) idx_inc = '0;
    else                  idx_inc = i + 1'b1;
  endfunction

  assign digit_ok = bus.i_digit_vld && (bus.i_digit <= 4'd9);

  // state and datapath registers; reset returns everything to an empty ENTRY
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_ENTRY;
      for (int k = 0; k < N; k++) smp_q[k] <= '0;
      cnt_q   <= '0;
      entry_q <= '0;
      index_q <= '0;
      reim_q  <= 1'b0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      index_q <= index_d;
      reim_q  <= reim_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // next-state logic; each state walks pulses in priority order so only one acts
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    index_d = index_q;
    reim_d  = reim_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    if (bus.i_clear) begin
      state_d = ST_ENTRY;
      for (int k = 0; k < N; k++) smp_d[k] = '0;
      cnt_d   = '0;
      entry_d = '0;
      index_d = '0;
      reim_d  = 1'b0;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (bus.i_enter) begin
            if (cnt_q == CNT_W'(N)) state_d = ST_START;
            else                    err_d   = 1'b1;
          end else if (bus.i_next) begin
            smp_d[index_q] = entry_q;
            entry_d        = '0;
            index_d        = idx_inc(index_q);
            if (cnt_q != CNT_W'(N)) cnt_d = cnt_q + 1'b1;
          end else if (digit_ok) begin
            entry_d = sat_mac(entry_q, bus.i_digit);
          end
        end
        ST_START: begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
        ST_WAIT: begin
          if (bus.i_fft_done) begin
            state_d = ST_SHOW;
            index_d = '0;
            reim_d  = 1'b0;
          end else if (timer_q == TMR_W'(DONE_TO-1)) begin
            state_d = ST_ERR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_SHOW: begin
          // enter and digit are swallowed but still outrank the lower pulses
          if (bus.i_enter || bus.i_next) begin
            if (!bus.i_enter) index_d = idx_inc(index_q);
          end else if (!digit_ok && bus.i_reim) begin
            reim_d = ~reim_q;
          end
        end
        ST_ERR: ;
        default: state_d = ST_ENTRY;
      endcase
    end
  end

  // outputs are pure decodes of registered state, so reset cannot produce a start glitch
  assign bus.o_fft_start = (state_q == ST_START);
  assign bus.o_show_fft  = (state_q == ST_SHOW);
  assign bus.o_err       = err_q || (state_q == ST_ERR);
  assign bus.o_entry_val = entry_q;
  assign bus.o_index     = index_q;
  assign bus.o_re_im     = reim_q;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign bus.o_fft_x[g*DATA_W +: DATA_W] = smp_q[g];
  end

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Directed bench for the keypad FFT sequencer: entry, launch, display, errors, clear.
module tb_fft8_seq_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   start_cnt = 0;

  fft8_seq_ctrl_if #(.DATA_W(8), .N(8), .IDX_W(3)) bus ();

  fft8_seq_ctrl #(.DATA_W(8), .N(8), .IDX_W(3), .DONE_TO(64)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_fft_start === 1'b1) start_cnt++;

  task automatic idle_inputs();
    bus.i_digit_vld = 0; bus.i_digit = 0; bus.i_next = 0; bus.i_enter = 0;
    bus.i_reim = 0; bus.i_clear = 0; bus.i_fft_done = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic dig(input logic [3:0] d);
    bus.i_digit_vld = 1; bus.i_digit = d; step();
  endtask
  task automatic nxt(); bus.i_next = 1; step(); endtask
  task automatic ent(); bus.i_enter = 1; step(); endtask
  task automatic rim(); bus.i_reim = 1; step(); endtask
  task automatic clr(); bus.i_clear = 1; step(); endtask
  task automatic don(); bus.i_fft_done = 1; step(); endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.o_fft_x !== 64'h0) begin n_fail++; $display("FAIL reset_fft_x got %h want 0", bus.o_fft_x); end
    n_cmp++; if (bus.o_entry_val !== 8'd0) begin n_fail++; $display("FAIL reset_entry got %0d want 0", bus.o_entry_val); end
    n_cmp++; if (bus.o_index !== 3'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", bus.o_index); end
    n_cmp++; if ({bus.o_fft_start, bus.o_show_fft, bus.o_re_im, bus.o_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.o_fft_start, bus.o_show_fft, bus.o_re_im, bus.o_err}); end
    rstn = 1;
    step();
  endtask

  task automatic test_run_fft();
    int s0;
    clr();
    for (int k = 1; k <= 8; k++) begin
      dig(4'(k));
      nxt();
    end
    n_cmp++; if (bus.o_fft_x !== 64'h0807060504030201) begin n_fail++; $display("FAIL run_buffer got %h want 0807060504030201", bus.o_fft_x); end
    n_cmp++; if (bus.o_index !== 3'd0) begin n_fail++; $display("FAIL run_index_wrap got %0d want 0", bus.o_index); end
    s0 = start_cnt;
    ent();
    n_cmp++; if (bus.o_fft_start !== 1'b1) begin n_fail++; $display("FAIL run_start got %b want 1", bus.o_fft_start); end
    step();
    n_cmp++; if (bus.o_fft_start !== 1'b0) begin n_fail++; $display("FAIL run_start_1cyc got %b want 0", bus.o_fft_start); end
    dig(4'd3);
    n_cmp++; if (bus.o_entry_val !== 8'd0) begin n_fail++; $display("FAIL wait_digit_ignored got %0d want 0", bus.o_entry_val); end
    repeat (3) step();
    don();
    n_cmp++; if (bus.o_show_fft !== 1'b1) begin n_fail++; $display("FAIL run_show got %b want 1", bus.o_show_fft); end
    n_cmp++; if (bus.o_index !== 3'd0 || bus.o_re_im !== 1'b0) begin
      n_fail++; $display("FAIL run_show_idx got idx=%0d reim=%b want 0/0", bus.o_index, bus.o_re_im); end
    n_cmp++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL run_start_count got %0d want 1", start_cnt - s0); end
    n_cmp++; if (bus.o_fft_x !== 64'h0807060504030201) begin n_fail++; $display("FAIL run_frozen got %h want 0807060504030201", bus.o_fft_x); end
  endtask

  task automatic test_show_nav();
    for (int i = 0; i < 8; i++) begin
      nxt();
      n_cmp++; if (bus.o_index !== 3'((i + 1) % 8)) begin
        n_fail++; $display("FAIL show_next_%0d got %0d want %0d", i, bus.o_index, (i + 1) % 8); end
    end
    rim();
    n_cmp++; if (bus.o_re_im !== 1'b1) begin n_fail++; $display("FAIL show_reim1 got %b want 1", bus.o_re_im); end
    rim();
    n_cmp++; if (bus.o_re_im !== 1'b0) begin n_fail++; $display("FAIL show_reim0 got %b want 0", bus.o_re_im); end
    dig(4'd5);
    don();
    ent();
    n_cmp++; if (bus.o_show_fft !== 1'b1 || bus.o_entry_val !== 8'd0 || bus.o_index !== 3'd0) begin
      n_fail++; $display("FAIL show_ignores got show=%b entry=%0d idx=%0d want 1/0/0", bus.o_show_fft, bus.o_entry_val, bus.o_index); end
  endtask

  task automatic test_saturate();
    clr();
    n_cmp++; if (bus.o_show_fft !== 1'b0 || bus.o_fft_x !== 64'h0) begin
      n_fail++; $display("FAIL clear_from_show got show=%b x=%h want 0/0", bus.o_show_fft, bus.o_fft_x); end
    dig(4'd9);
    dig(4'd9);
    n_cmp++; if (bus.o_entry_val !== 8'd99) begin n_fail++; $display("FAIL sat_99 got %0d want 99", bus.o_entry_val); end
    dig(4'd9);
    n_cmp++; if (bus.o_entry_val !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d want 255", bus.o_entry_val); end
    dig(4'd12);
    n_cmp++; if (bus.o_entry_val !== 8'd255) begin n_fail++; $display("FAIL sat_bad_digit got %0d want 255", bus.o_entry_val); end
    nxt();
    n_cmp++; if (bus.o_fft_x !== 64'h00000000000000FF || bus.o_entry_val !== 8'd0 || bus.o_index !== 3'd1) begin
      n_fail++; $display("FAIL sat_commit got x=%h entry=%0d idx=%0d want ..FF/0/1", bus.o_fft_x, bus.o_entry_val, bus.o_index); end
    clr();
    dig(4'd2); dig(4'd5); dig(4'd6);
    n_cmp++; if (bus.o_entry_val !== 8'd255) begin n_fail++; $display("FAIL sat_256 got %0d want 255", bus.o_entry_val); end
    clr();
    dig(4'd2); dig(4'd5); dig(4'd5);
    n_cmp++; if (bus.o_entry_val !== 8'd255) begin n_fail++; $display("FAIL exact_255 got %0d want 255", bus.o_entry_val); end
    clr();
    dig(4'd2); dig(4'd5); dig(4'd4);
    n_cmp++; if (bus.o_entry_val !== 8'd254) begin n_fail++; $display("FAIL exact_254 got %0d want 254", bus.o_entry_val); end
  endtask

  task automatic test_early_enter();
    int s0;
    clr();
    for (int k = 0; k < 5; k++) nxt();
    s0 = start_cnt;
    ent();
    n_cmp++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL early_err got %b want 1", bus.o_err); end
    step();
    n_cmp++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL early_err_pulse got %b want 0", bus.o_err); end
    n_cmp++; if (start_cnt !== s0 || bus.o_index !== 3'd5 || bus.o_show_fft !== 1'b0) begin
      n_fail++; $display("FAIL early_state got starts=%0d idx=%0d show=%b want %0d/5/0", start_cnt, bus.o_index, bus.o_show_fft, s0); end
    dig(4'd4);
    n_cmp++; if (bus.o_entry_val !== 8'd4) begin n_fail++; $display("FAIL early_still_entry got %0d want 4", bus.o_entry_val); end
  endtask

  task automatic test_timeout();
    clr();
    dig(4'd6);
    for (int k = 0; k < 8; k++) nxt();
    ent();
    step();
    repeat (63) step();
    n_cmp++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b want 0", bus.o_err); end
    step();
    n_cmp++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", bus.o_err); end
    nxt(); ent(); don(); step();
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_show_fft !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky got err=%b show=%b want 1/0", bus.o_err, bus.o_show_fft); end
    clr();
    n_cmp++; if (bus.o_err !== 1'b0 || bus.o_fft_x !== 64'h0 || bus.o_index !== 3'd0) begin
      n_fail++; $display("FAIL err_clear got err=%b x=%h idx=%0d want 0/0/0", bus.o_err, bus.o_fft_x, bus.o_index); end
  endtask

  task automatic test_priority();
    int s0;
    clr();
    dig(4'd3); nxt(); dig(4'd7);
    bus.i_clear = 1; bus.i_enter = 1; bus.i_next = 1; bus.i_digit_vld = 1; bus.i_digit = 4'd2;
    step();
    n_cmp++; if (bus.o_fft_x !== 64'h0 || bus.o_entry_val !== 8'd0 || bus.o_index !== 3'd0 || bus.o_err !== 1'b0) begin
      n_fail++; $display("FAIL prio_clear got x=%h entry=%0d idx=%0d err=%b want 0/0/0/0", bus.o_fft_x, bus.o_entry_val, bus.o_index, bus.o_err); end
    bus.i_enter = 1; bus.i_next = 1;
    step();
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_index !== 3'd0) begin
      n_fail++; $display("FAIL prio_enter_next got err=%b idx=%0d want 1/0", bus.o_err, bus.o_index); end
    dig(4'd7);
    bus.i_next = 1; bus.i_digit_vld = 1; bus.i_digit = 4'd4;
    step();
    n_cmp++; if (bus.o_fft_x !== 64'h07 || bus.o_entry_val !== 8'd0 || bus.o_index !== 3'd1) begin
      n_fail++; $display("FAIL prio_next_digit got x=%h entry=%0d idx=%0d want 07/0/1", bus.o_fft_x, bus.o_entry_val, bus.o_index); end
    for (int k = 0; k < 7; k++) nxt();
    ent();
    step();
    clr();
    s0 = start_cnt;
    don();
    n_cmp++; if (bus.o_show_fft !== 1'b0 || start_cnt !== s0) begin
      n_fail++; $display("FAIL late_done got show=%b starts=%0d want 0/%0d", bus.o_show_fft, start_cnt, s0); end
    dig(4'd2);
    n_cmp++; if (bus.o_entry_val !== 8'd2) begin n_fail++; $display("FAIL late_done_entry got %0d want 2", bus.o_entry_val); end
  endtask

  task automatic test_async_reset();
    int s0;
    clr();
    for (int k = 0; k < 8; k++) begin dig(4'd1); nxt(); end
    ent();
    step();
    don();
    s0 = start_cnt;
    #2 rstn = 0;
    #1;
    n_cmp++; if (bus.o_show_fft !== 1'b0 || bus.o_fft_x !== 64'h0 || bus.o_index !== 3'd0) begin
      n_fail++; $display("FAIL async_reset got show=%b x=%h idx=%0d want 0/0/0", bus.o_show_fft, bus.o_fft_x, bus.o_index); end
    step();
    rstn = 1;
    step();
    n_cmp++; if (start_cnt !== s0 || bus.o_fft_start !== 1'b0) begin
      n_fail++; $display("FAIL async_no_start got starts=%0d want %0d", start_cnt, s0); end
  endtask

  initial begin
    test_reset();
    test_run_fft();
    test_show_nav();
    test_saturate();
    test_early_enter();
    test_timeout();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
